// File: rtl/ceespu_writeback.sv
// Writeback stage: two 2-deep result queues (ALU and load/MEM) feeding a
// single register-file write port. MEM results win arbitration by default;
// a starve counter forces an ALU grant after STARVE_MAX consecutive MEM grants
// made while ALU results were waiting.

// Two-entry {sel, data} queue. The parent only pushes when not full and
// only pops when not empty.
module ceespu_writeback_fifo (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_push,
  input  logic [4:0]  I_sel,
  input  logic [31:0] I_data,
  input  logic        I_pop,
  output logic        O_empty,
  output logic        O_full,
  output logic [4:0]  O_head_sel,
  output logic [31:0] O_head_data,
  output logic [31:0] O_pend
);

  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0][4:0]   sel_q, sel_d;
  logic [1:0][31:0]  data_q, data_d;

  // Next-state for pointers, count and storage.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sel_d    = sel_q;
    data_d   = data_q;
    if (I_push) begin
      sel_d[wr_ptr_q]  = I_sel;
      data_d[wr_ptr_q] = I_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (I_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // Push and pop together leave the count unchanged.
    case ({I_push, I_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state: cleared asynchronously so the queue empties at once.
  always_ff @(posedge I_clk or negedge I_rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!I_rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage: validity comes from count/pointers, so no reset is needed.
  always_ff @(posedge I_clk) begin
    // NOTE: storage arrays are deliberately not reset; only the control state qualifies them.
    sel_q  <= sel_d;
    data_q <= data_d;
  end

  assign O_empty     = (count_q == 2'd0);
  assign O_full      = (count_q == 2'd2);
  assign O_head_sel  = sel_q[rd_ptr_q];
  assign O_head_data = data_q[rd_ptr_q];

  // Decoded destination of every occupied slot.
  always_comb begin
    O_pend = 32'd0;
    for (int i = 0; i < 2; i++) begin
      if ((count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(i)))) begin
        O_pend = O_pend | (32'd1 << sel_q[i]);
      end
    end
  end

endmodule

module ceespu_writeback #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_alu_valid,
  input  logic [4:0]  I_alu_sel,
  input  logic [31:0] I_alu_data,
  output logic        O_alu_ready,
  input  logic        I_mem_valid,
  input  logic [4:0]  I_mem_sel,
  input  logic [31:0] I_mem_data,
  output logic        O_mem_ready,
  output logic        O_we,
  output logic [4:0]  O_selD,
  output logic [31:0] O_dataD,
  output logic [31:0] O_pend
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic          alu_empty, alu_full, mem_empty, mem_full;
  logic [4:0]    alu_head_sel, mem_head_sel;
  logic [31:0]   alu_head_data, mem_head_data;
  logic [31:0]   alu_pend, mem_pend;
  logic          alu_push, mem_push;
  logic          grant_alu, grant_mem;

  logic          rst_done_q, rst_done_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          we_q, we_d;
  logic [4:0]    sel_q, sel_d;
  logic [31:0]   data_q, data_d;

  // Ready depends on registered state only; held low until the first edge after reset.
  assign O_alu_ready = rst_done_q & ~alu_full;
  assign O_mem_ready = rst_done_q & ~mem_full;
  assign alu_push    = I_alu_valid & O_alu_ready;
  assign mem_push    = I_mem_valid & O_mem_ready;

  ceespu_writeback_fifo u_alu_fifo (
    .I_clk       (I_clk),
    .I_rst       (I_rst),
    .I_push      (alu_push),
    .I_sel       (I_alu_sel),
    .I_data      (I_alu_data),
    .I_pop       (grant_alu),
    .O_empty     (alu_empty),
    .O_full      (alu_full),
    .O_head_sel  (alu_head_sel),
    .O_head_data (alu_head_data),
    .O_pend      (alu_pend)
  );

  ceespu_writeback_fifo u_mem_fifo (
    .I_clk       (I_clk),
    .I_rst       (I_rst),
    .I_push      (mem_push),
    .I_sel       (I_mem_sel),
    .I_data      (I_mem_data),
    .I_pop       (grant_mem),
    .O_empty     (mem_empty),
    .O_full      (mem_full),
    .O_head_sel  (mem_head_sel),
    .O_head_data (mem_head_data),
    .O_pend      (mem_pend)
  );

  // Arbitration, starve counter and next write-port contents.
  always_comb begin
    grant_alu  = ~alu_empty & (mem_empty | (starve_q == SW'(STARVE_MAX)));
    grant_mem  = ~mem_empty & ~grant_alu;
    rst_done_d = 1'b1;

    starve_d = starve_q;
    if (grant_alu || alu_empty) begin
      starve_d = '0;
    end else if (grant_mem) begin
      starve_d = starve_q + SW'(1);
    end

    we_d   = grant_alu | grant_mem;
    sel_d  = sel_q;
    data_d = data_q;
    if (grant_mem) begin
      sel_d  = mem_head_sel;
      data_d = mem_head_data;
    end else if (grant_alu) begin
      sel_d  = alu_head_sel;
      data_d = alu_head_data;
    end
  end

  // Registered write port and arbiter state.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      rst_done_q <= 1'b0;
      starve_q   <= '0;
      we_q       <= 1'b0;
      sel_q      <= 5'd0;
      data_q     <= 32'd0;
    end else begin
      rst_done_q <= rst_done_d;
      starve_q   <= starve_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
    end
  end

  assign O_we    = we_q;
  assign O_selD  = sel_q;
  assign O_dataD = data_q;
  assign O_pend  = alu_pend | mem_pend | (we_q ? (32'd1 << sel_q) : 32'd0);

endmodule

// File: doc/ceespu_writeback.md
CEESPU_WRITEBACK -- requirements
Module: ceespu_writeback

Interface
REQ-001 The module SHALL have parameter STARVE_MAX, default 3: the maximum number of consecutive MEM grants issued while ALU has a queued entry.
REQ-002 The module SHALL have port I_clk, input, 1: the single clock; all state updates on rising edge.
REQ-003 The module SHALL have port I_rst, input, 1: asynchronous, active-low reset.
REQ-004 The module SHALL have port I_alu_valid, input, 1: ALU result offered.
REQ-005 The module SHALL have port I_alu_sel, input, 5: ALU destination register.
REQ-006 The module SHALL have port I_alu_data, input, 32: ALU result.
REQ-007 The module SHALL have port O_alu_ready, output, 1: ALU queue can accept.
REQ-008 The module SHALL have port I_mem_valid, input, 1: load result offered.
REQ-009 The module SHALL have port I_mem_sel, input, 5: load destination register.
REQ-010 The module SHALL have port I_mem_data, input, 32: load data.
REQ-011 The module SHALL have port O_mem_ready, output, 1: MEM queue can accept.
REQ-012 The module SHALL have port O_we, output, 1: register-file write enable.
REQ-013 The module SHALL have port O_selD, output, 5: register-file write address.
REQ-014 The module SHALL have port O_dataD, output, 32: register-file write data.
REQ-015 The module SHALL have port O_pend, output, 32: bit n is set while any queued or issuing write targets register n.

Function
REQ-016 Each source (ALU, MEM) SHALL own a 2-entry FIFO of {sel, data}.
REQ-017 A transfer SHALL occur on a rising edge when valid and ready are both 1.
REQ-018 O_x_ready SHALL be 1 exactly when that FIFO holds fewer than 2 entries, computed from registered count only, with no dependence on the same-cycle dequeue.
REQ-019 A simultaneous enqueue and dequeue on one FIFO SHALL leave its count unchanged and preserve FIFO order.
REQ-020 Each cycle the arbiter SHALL grant at most one FIFO head: MEM if non-empty, else ALU if non-empty, else none.
REQ-021 Anti-starvation: starve counter SHALL increment on each MEM grant while ALU is non-empty.
REQ-022 The starve counter SHALL clear on any ALU grant or whenever ALU is empty.
REQ-023 When the starve counter equals STARVE_MAX and ALU is non-empty, ALU SHALL be granted instead of MEM.
REQ-024 A granted entry SHALL be dequeued at that edge and presented registered: O_we=1 with O_selD/O_dataD for exactly the following cycle (latency 1 from grant, 2 from input transfer).
REQ-025 O_we SHALL be 0 in any cycle following a no-grant cycle; O_selD and O_dataD then hold their last values.
REQ-026 Writes to register 0 SHALL be issued like any other register, with no suppression.
REQ-027 Commit order SHALL be grant order; no same-register reordering check is performed.
REQ-028 O_pend SHALL be the OR of decoded sel fields of all valid FIFO entries and of O_selD when O_we=1, computed combinationally from registered state.
REQ-029 Sustained throughput SHALL be one write per cycle while any FIFO is non-empty.

Reset
REQ-030 While I_rst=0, both FIFOs SHALL be empty, the starve counter 0, O_we=0, O_selD=0, O_dataD=0, and O_pend=0, asynchronously.
REQ-031 O_alu_ready and O_mem_ready SHALL be 0 while I_rst=0 and 1 from the first edge after release.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries; no write SHALL be issued after release until new transfers occur.

Verification
REQ-033 Single ALU write: alu sel=5, data=0x12345678 for one cycle -> O_we=1, O_selD=5, O_dataD=0x12345678 two cycles after the transfer; O_pend[5]=1 from the cycle after the transfer until O_we drops.
REQ-034 Simultaneous offer: ALU (sel=1, 0xA) and MEM (sel=2, 0xB) in the same cycle -> writes reg2=0xB, then reg1=0xA on consecutive cycles.
REQ-035 Starvation: MEM valid continuously and ALU one entry queued, STARVE_MAX=3 -> grant order MEM, MEM, MEM, ALU, then MEM resumes.
REQ-036 Backpressure: with the output blocked by continuous MEM traffic, hold ALU valid -> O_alu_ready drops after 2 accepted entries and no ALU data is lost or duplicated.
REQ-037 Reset mid-stream: assert I_rst=0 with 2 entries per FIFO -> outputs 0 immediately; after release, O_we stays 0 and both ready signals are 1.
